// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register: valid/ready handshake, one main entry
// plus one skid entry, synchronous flush that empties the stage. in_ready is
// a registered signal, so stalls never form a combinational ready chain.
module pipe_stage_skid #(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Empty entries carry the bubble payload, so out_data is never stale.
  localparam entry_t EMPTY = '{vld: 1'b0, data: BUBBLE};

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   ready_q;
  logic   accept, drain;

  assign accept = in_valid & ready_q;
  assign drain  = main_q.vld & out_ready;

  // Next-state for both entries; the skid only fills while the main entry is stalled.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = EMPTY;
      skid_d = EMPTY;
    end else if (!main_q.vld) begin
      if (accept) main_d = '{vld: 1'b1, data: in_data};
    end else if (drain) begin
      if (skid_q.vld) begin
        // Skid is older than anything arriving now; in_ready was 0, so no accept.
        main_d = skid_q;
        skid_d = EMPTY;
      end else if (accept) begin
        main_d = '{vld: 1'b1, data: in_data};
      end else begin
        main_d = EMPTY;
      end
    end else if (accept) begin
      skid_d = '{vld: 1'b1, data: in_data};
    end
  end

  // Storage plus registered ready; async clear discards everything held.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      main_q  <= EMPTY;
      skid_q  <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ~skid_d.vld;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_q.vld;
  assign out_data  = main_q.data;
  assign occupancy = {1'b0, main_q.vld} + {1'b0, skid_q.vld};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios with literal expectations,
// then randomized traffic against a 2-deep FIFO queue model.
module tb_pipe_stage_skid;

  localparam int         W   = 8;
  localparam logic [7:0] BUB = 8'hA5;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int npass = 0;
  int ntot  = 0;
  logic [W-1:0] q[$];

  pipe_stage_skid #(.DATA_W(W), .BUBBLE(BUB)) dut (
    .clk(clk), .clr(clr), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Compare DUT outputs against what the queue model says they must be.
  task automatic cmp_model();
    chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("m_out_data",  32'(out_data),  32'((q.size() > 0) ? q[0] : BUB));
    chk("m_in_ready",  32'(in_ready),  32'(q.size() < 2));
    chk("m_occupancy", 32'(occupancy), 32'(q.size()));
  endtask

  // Drive one cycle of inputs (called at negedge), advance the model at the
  // edge using pre-edge state, then check at the following negedge.
  task automatic step(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
    bit acc, drn;
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    @(posedge clk);
    acc = iv && (q.size() < 2);
    drn = ordy && (q.size() > 0);
    if (fl) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    @(negedge clk);
    cmp_model();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'(BUB));
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    clr = 1'b1;
    @(negedge clk);

    // Streaming
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'(21 + i), 1'b1, 1'b0);
      chk("stream_data",  32'(out_data), 32'(21 + i));
      chk("stream_ready", 32'(in_ready), 32'd1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_empty", 32'(out_valid), 32'd0);

    // Stall into skid
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    step(1'b1, 8'h0B, 1'b0, 1'b0);
    chk("skid_data",  32'(out_data),  32'h0A);
    chk("skid_occ",   32'(occupancy), 32'd2);
    chk("skid_ready", 32'(in_ready),  32'd0);
    step(1'b1, 8'h77, 1'b0, 1'b0);  // refused: in_ready=0
    chk("skid_hold",  32'(out_data),  32'h0A);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rel_data_b", 32'(out_data),  32'h0B);
    chk("rel_occ",    32'(occupancy), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rel_empty",  32'(out_valid), 32'd0);
    chk("rel_bubble", 32'(out_data),  32'(BUB));

    // Flush with full stage and simultaneous input
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h0C, 1'b0, 1'b1);
    chk("fl_occ",    32'(occupancy), 32'd0);
    chk("fl_data",   32'(out_data),  32'(BUB));
    chk("fl_valid",  32'(out_valid), 32'd0);
    chk("fl_ready",  32'(in_ready),  32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fl_no_c",   32'(out_valid), 32'd0);

    // Async reset mid-stream with occupancy 2
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    clr = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data",  32'(out_data),  32'(BUB));
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_occupancy", 32'(occupancy), 32'd0);
    q.delete();
    #1 clr = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_empty", 32'(out_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      step(bit'($urandom_range(0, 1)), 8'($urandom),
           $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 4);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
